// File: rtl/crc_engine.sv
// crc_engine: run-time configurable CRC engine folding BITS_PER_CYCLE message bits per clock.
// Define CRC_ENGINE_REFLECT_EN to build in input-word and result reflection (cfg_refin/cfg_refout).
module crc_engine #(
    parameter int CRC_SIZE       = 32,
    parameter int DATA_WIDTH     = 8,
    parameter int BITS_PER_CYCLE = 8,
    parameter int SIZE_W         = $clog2(CRC_SIZE) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [SIZE_W-1:0]     cfg_size,
    input  logic [CRC_SIZE-1:0]   cfg_poly,
    input  logic [CRC_SIZE-1:0]   cfg_init,
    input  logic [CRC_SIZE-1:0]   cfg_xorout,
    input  logic                  cfg_refin,
    input  logic                  cfg_refout,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_valid,
    input  logic                  data_last,
    output logic                  data_ready,
    output logic                  busy,
    output logic [CRC_SIZE-1:0]   crc_out,
    output logic                  crc_valid
);

    localparam int N     = DATA_WIDTH / BITS_PER_CYCLE;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_DATA = 2'd1,
        SHIFT     = 2'd2,
        DONE      = 2'd3
    } state_t;

    state_t                state_r, state_s;
    logic [CRC_SIZE-1:0]   crc_r, crc_s, crc_out_r, crc_out_s;
    logic [CRC_SIZE-1:0]   mask_r, top_r, poly_r, xorout_r;
    logic [CRC_SIZE-1:0]   cfg_mask_s, step_s, result_s;
    logic [SIZE_W-1:0]     size_s;
    logic [DATA_WIDTH-1:0] word_r, word_s, word_in_s;
    logic [BITS_PER_CYCLE-1:0] chunk_s;
    logic [CNT_W-1:0]      cnt_r, cnt_s;
    logic                  last_r, last_s;
    logic                  crc_valid_r, crc_valid_s;
    logic                  data_ready_r, busy_r;

    function automatic logic [CRC_SIZE-1:0] width_mask(input logic [SIZE_W-1:0] w);
        logic [CRC_SIZE-1:0] m;
        for (int i = 0; i < CRC_SIZE; i++) begin
            m[i] = (i < int'(w));
        end
        return m;
    endfunction

    // top marks bit W-1, so no variable bit index is needed for the feedback tap
    function automatic logic [CRC_SIZE-1:0] crc_step(
        input logic [CRC_SIZE-1:0]       crc,
        input logic [BITS_PER_CYCLE-1:0] chunk,
        input logic [CRC_SIZE-1:0]       poly,
        input logic [CRC_SIZE-1:0]       mask,
        input logic [CRC_SIZE-1:0]       top
    );
        logic [CRC_SIZE-1:0] c;
        logic                fb;
        c = crc;
        for (int i = BITS_PER_CYCLE - 1; i >= 0; i--) begin
            fb = (|(c & top)) ^ chunk[i];
            c  = ((c << 1) & mask) ^ (fb ? poly : {CRC_SIZE{1'b0}});
        end
        return c;
    endfunction

    // zero or oversize widths select the full register
    always_comb begin
        if ((cfg_size == {SIZE_W{1'b0}}) || (cfg_size > SIZE_W'(CRC_SIZE))) begin
            size_s = SIZE_W'(CRC_SIZE);
        end else begin
            size_s = cfg_size;
        end
    end

    assign cfg_mask_s = width_mask(size_s);

`ifdef CRC_ENGINE_REFLECT_EN
    logic [SIZE_W-1:0] width_r;
    logic              refin_r, refout_r;

    function automatic logic [DATA_WIDTH-1:0] reflect_word(input logic [DATA_WIDTH-1:0] d);
        logic [DATA_WIDTH-1:0] r;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            r[i] = d[DATA_WIDTH-1-i];
        end
        return r;
    endfunction

    function automatic logic [CRC_SIZE-1:0] reflect_crc(input logic [CRC_SIZE-1:0] c,
                                                        input logic [SIZE_W-1:0]   w);
        logic [CRC_SIZE-1:0] r;
        for (int i = 0; i < CRC_SIZE; i++) begin
            r[i] = c[CRC_SIZE-1-i];
        end
        return r >> (SIZE_W'(CRC_SIZE) - w);
    endfunction

    // reflection controls are captured with the rest of the configuration
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            width_r  <= {SIZE_W{1'b0}};
            refin_r  <= 1'b0;
            refout_r <= 1'b0;
        end else if (start) begin
            width_r  <= size_s;
            refin_r  <= cfg_refin;
            refout_r <= cfg_refout;
        end
    end

    assign word_in_s = refin_r ? reflect_word(data_in) : data_in;
    assign result_s  = ((refout_r ? reflect_crc(step_s, width_r) : step_s) ^ xorout_r) & mask_r;
`else
    logic unused_reflect_s;
    assign unused_reflect_s = cfg_refin ^ cfg_refout;
    assign word_in_s        = data_in;
    assign result_s         = (step_s ^ xorout_r) & mask_r;
`endif

    // configuration is sampled only on start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_r   <= {CRC_SIZE{1'b0}};
            top_r    <= {CRC_SIZE{1'b0}};
            poly_r   <= {CRC_SIZE{1'b0}};
            xorout_r <= {CRC_SIZE{1'b0}};
        end else if (start) begin
            mask_r   <= cfg_mask_s;
            top_r    <= cfg_mask_s & ~(cfg_mask_s >> 1);
            poly_r   <= cfg_poly & cfg_mask_s;
            xorout_r <= cfg_xorout & cfg_mask_s;
        end
    end

    // first chunk comes straight from the input word, later ones from the held remainder
    always_comb begin
        if (state_r == SHIFT) begin
            chunk_s = word_r[DATA_WIDTH-1 -: BITS_PER_CYCLE];
        end else begin
            chunk_s = word_in_s[DATA_WIDTH-1 -: BITS_PER_CYCLE];
        end
    end

    assign step_s = crc_step(crc_r, chunk_s, poly_r, mask_r, top_r);

    // next-state and datapath update; start overrides everything including a pending word
    always_comb begin
        state_s     = state_r;
        crc_s       = crc_r;
        word_s      = word_r;
        cnt_s       = cnt_r;
        last_s      = last_r;
        crc_out_s   = crc_out_r;
        crc_valid_s = crc_valid_r;
        if (start) begin
            state_s     = WAIT_DATA;
            crc_s       = cfg_init & cfg_mask_s;
            word_s      = {DATA_WIDTH{1'b0}};
            cnt_s       = {CNT_W{1'b0}};
            last_s      = 1'b0;
            crc_out_s   = {CRC_SIZE{1'b0}};
            crc_valid_s = 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    state_s = IDLE;
                end
                WAIT_DATA: begin
                    if (data_valid) begin
                        crc_s  = step_s;
                        word_s = word_in_s << BITS_PER_CYCLE;
                        cnt_s  = CNT_W'(N - 1);
                        last_s = data_last;
                        if (N > 1) begin
                            state_s = SHIFT;
                        end else if (data_last) begin
                            state_s     = DONE;
                            crc_out_s   = result_s;
                            crc_valid_s = 1'b1;
                        end else begin
                            state_s = WAIT_DATA;
                        end
                    end else begin
                        state_s = WAIT_DATA;
                    end
                end
                SHIFT: begin
                    crc_s  = step_s;
                    word_s = word_r << BITS_PER_CYCLE;
                    cnt_s  = cnt_r - CNT_W'(1);
                    if (cnt_r == CNT_W'(1)) begin
                        if (last_r) begin
                            state_s     = DONE;
                            crc_out_s   = result_s;
                            crc_valid_s = 1'b1;
                        end else begin
                            state_s = WAIT_DATA;
                        end
                    end else begin
                        state_s = SHIFT;
                    end
                end
                DONE: begin
                    state_s = DONE;
                end
                default: begin
                    state_s = IDLE;
                end
            endcase
        end
    end

    // state, datapath and registered status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            crc_r        <= {CRC_SIZE{1'b0}};
            word_r       <= {DATA_WIDTH{1'b0}};
            cnt_r        <= {CNT_W{1'b0}};
            last_r       <= 1'b0;
            crc_out_r    <= {CRC_SIZE{1'b0}};
            crc_valid_r  <= 1'b0;
            data_ready_r <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_s;
            crc_r        <= crc_s;
            word_r       <= word_s;
            cnt_r        <= cnt_s;
            last_r       <= last_s;
            crc_out_r    <= crc_out_s;
            crc_valid_r  <= crc_valid_s;
            data_ready_r <= (state_s == WAIT_DATA);
            busy_r       <= (state_s == WAIT_DATA) || (state_s == SHIFT);
        end
    end

    assign data_ready = data_ready_r;
    assign busy       = busy_r;
    assign crc_out    = crc_out_r;
    assign crc_valid  = crc_valid_r;

endmodule

// File: tb/tb_crc_engine.sv
// tb_crc_engine: directed vectors for crc_engine; instance a is CRC-8 with one word per clock,
// instance b is 32-bit with one bit per clock (8 cycles per word).
module tb_crc_engine;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_a = 1'b0, start_b = 1'b0, valid_a = 1'b0, valid_b = 1'b0;
    logic        data_last = 1'b0, cfg_refin = 1'b0, cfg_refout = 1'b0;
    logic [5:0]  cfg_size = 6'd0;
    logic [31:0] cfg_poly = 32'h0, cfg_init = 32'h0, cfg_xorout = 32'h0;
    logic [7:0]  data_in = 8'h0;
    logic        ready_a, busy_a, crc_valid_a, ready_b, busy_b, crc_valid_b;
    logic [7:0]  crc_a;
    logic [31:0] crc_b;
    int          n_vec = 0;
    int          n_bad = 0;

`ifdef CRC_ENGINE_REFLECT_EN
    localparam logic [31:0] EXP_CRC32 = 32'hCBF43926;
`else
    localparam logic [31:0] EXP_CRC32 = 32'hFC891918;
`endif

    always #5 clk = ~clk;

    crc_engine #(.CRC_SIZE(8), .DATA_WIDTH(8), .BITS_PER_CYCLE(8)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .cfg_size(cfg_size[3:0]),
        .cfg_poly(cfg_poly[7:0]), .cfg_init(cfg_init[7:0]), .cfg_xorout(cfg_xorout[7:0]),
        .cfg_refin(cfg_refin), .cfg_refout(cfg_refout), .data_in(data_in),
        .data_valid(valid_a), .data_last(data_last), .data_ready(ready_a), .busy(busy_a),
        .crc_out(crc_a), .crc_valid(crc_valid_a)
    );

    crc_engine #(.CRC_SIZE(32), .DATA_WIDTH(8), .BITS_PER_CYCLE(1)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .cfg_size(cfg_size),
        .cfg_poly(cfg_poly), .cfg_init(cfg_init), .cfg_xorout(cfg_xorout),
        .cfg_refin(cfg_refin), .cfg_refout(cfg_refout), .data_in(data_in),
        .data_valid(valid_b), .data_last(data_last), .data_ready(ready_b), .busy(busy_b),
        .crc_out(crc_b), .crc_valid(crc_valid_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic rdy(input bit s);
        return s ? ready_b : ready_a;
    endfunction

    function automatic logic cv(input bit s);
        return s ? crc_valid_b : crc_valid_a;
    endfunction

    function automatic logic [31:0] crc(input bit s);
        return s ? crc_b : {24'h0, crc_a};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_valid(input bit s, input logic v);
        if (s) valid_b = v;
        else   valid_a = v;
    endtask

    task automatic do_start(input bit s, input logic [5:0] size, input logic [31:0] poly,
                            input logic [31:0] init, input logic [31:0] xo, input logic refl,
                            input logic with_valid);
        cfg_size   = size;
        cfg_poly   = poly;
        cfg_init   = init;
        cfg_xorout = xo;
        cfg_refin  = refl;
        cfg_refout = refl;
        if (s) start_b = 1'b1;
        else   start_a = 1'b1;
        set_valid(s, with_valid);
        tick();
        start_a = 1'b0;
        start_b = 1'b0;
        set_valid(s, 1'b0);
        check("start_ready", 32'(rdy(s)), 32'h1);
        check("start_valid_clr", 32'(cv(s)), 32'h0);
    endtask

    // handshake one word, then measure the ready gap (or the result latency for the last word)
    task automatic send_word(input bit s, input logic [7:0] d, input logic last);
        int k;
        int gap;
        k = 0;
        while (!rdy(s) && k < 20) begin
            tick();
            k++;
        end
        check("ready_wait", 32'(rdy(s)), 32'h1);
        data_in   = d;
        data_last = last;
        set_valid(s, 1'b1);
        tick();
        set_valid(s, 1'b0);
        data_last = 1'b0;
        gap = 0;
        if (last) begin
            while (!cv(s) && gap < 20) begin
                tick();
                gap++;
            end
            check("latency", 32'(gap), s ? 32'd7 : 32'd0);
        end else begin
            while (!rdy(s) && gap < 20) begin
                tick();
                gap++;
            end
            check("ready_gap", 32'(gap), s ? 32'd7 : 32'd0);
        end
    endtask

    task automatic send_msg(input bit s, input int nwords, input logic with_last);
        for (int i = 0; i < nwords; i++) begin
            send_word(s, 8'h31 + 8'(i), with_last && (i == nwords - 1));
        end
    endtask

    task automatic run_crc(input bit s, input logic [5:0] size, input logic [31:0] poly,
                           input logic [31:0] init, input logic [31:0] xo, input logic refl,
                           input logic [31:0] exp, input string tag);
        do_start(s, size, poly, init, xo, refl, 1'b0);
        send_msg(s, 9, 1'b1);
        check(tag, crc(s), exp);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at %0t, limit 1000000", $time);
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_a", 32'({ready_a, busy_a, crc_valid_a, crc_a}), 32'h0);
        check("reset_b", 32'({ready_b, busy_b, crc_valid_b}), 32'h0);
        check("reset_crc_b", crc_b, 32'h0);
        rst_n = 1'b1;
        tick();

        // words offered before any start are ignored
        data_in = 8'h31;
        valid_a = 1'b1;
        repeat (2) tick();
        valid_a = 1'b0;
        check("idle_ready", 32'({ready_a, busy_a}), 32'h0);

        run_crc(1'b0, 6'd8, 32'h07, 32'h00, 32'h00, 1'b0, 32'hF4, "crc8");

        // DONE ignores further words and holds the result
        data_in = 8'hA5;
        valid_a = 1'b1;
        repeat (3) tick();
        valid_a = 1'b0;
        check("done_hold_crc", 32'(crc_a), 32'hF4);
        check("done_hold_valid", 32'(crc_valid_a), 32'h1);
        check("done_ready", 32'(ready_a), 32'h0);

        // abort mid-message, restart with size 0 and a word offered together with start
        do_start(1'b0, 6'd8, 32'h1D, 32'hFF, 32'h00, 1'b0, 1'b0);
        send_msg(1'b0, 4, 1'b0);
        check("abort_no_valid", 32'(crc_valid_a), 32'h0);
        data_in = 8'h55;
        do_start(1'b0, 6'd0, 32'h07, 32'h00, 32'h00, 1'b0, 1'b1);
        send_msg(1'b0, 9, 1'b1);
        check("abort_crc8", 32'(crc_a), 32'hF4);

        run_crc(1'b0, 6'd15, 32'h07, 32'h00, 32'h00, 1'b0, 32'hF4, "crc8_oversize");

        run_crc(1'b1, 6'd16, 32'h1021, 32'hFFFF, 32'h0, 1'b0, 32'h29B1, "ccitt_false");
        check("ccitt_upper_zero", 32'(crc_b[31:16]), 32'h0);
        run_crc(1'b1, 6'd16, 32'h1021, 32'h0000, 32'h0, 1'b0, 32'h31C3, "xmodem");
        run_crc(1'b1, 6'd0, 32'h04C11DB7, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, EXP_CRC32, "crc32");

        // reset while a word is being shifted in
        do_start(1'b1, 6'd16, 32'h1021, 32'hFFFF, 32'h0, 1'b0, 1'b0);
        data_in = 8'h31;
        valid_b = 1'b1;
        tick();
        valid_b = 1'b0;
        repeat (2) tick();
        check("shift_busy", 32'({busy_b, ready_b}), 32'h2);
        rst_n = 1'b0;
        #1;
        check("reset_mid_flags", 32'({ready_b, busy_b, crc_valid_b}), 32'h0);
        check("reset_mid_crc", crc_b, 32'h0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        valid_b = 1'b1;
        repeat (4) tick();
        valid_b = 1'b0;
        check("post_reset_idle", 32'({ready_b, busy_b, crc_valid_b}), 32'h0);
        run_crc(1'b1, 6'd16, 32'h1021, 32'h0000, 32'h0, 1'b0, 32'h31C3, "xmodem_after_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
